alu_issue_ctrl: RTL and testbench

Initiator side of the ALU operand/opcode/done interface. It accepts one operation at a time from an upstream valid/ready request channel and drives A, B and S into the ALU. For op 3'b111 (mod) it pulses the mod unit's restart and waits for done. It returns the captured result on a valid/ready response channel with an error flag. It sits between the datapath control and the alu instance, so no upstream logic ever handles the multi-cycle mod timing.

---
 rtl/alu_issue_ctrl_if.sv | 33 +++
 rtl/alu_issue_ctrl.sv | 131 +++++++++++++
 tb/tb_alu_issue_ctrl.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_ctrl_if.sv
// Bundle of the request, ALU-side and response signals of the ALU issue
// controller. The controller uses the master view; the upstream/downstream
// logic and the ALU instance use the slave view.
interface alu_issue_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_s;
    logic        alu_rst;
    logic [31:0] alu_res;
    logic        alu_done;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        busy;

    modport master (
        input  req_valid, req_op, req_a, req_b, alu_res, alu_done, rsp_ready,
        output req_ready, alu_a, alu_b, alu_s, alu_rst, rsp_valid, rsp_data,
        output rsp_err, busy
    );

    modport slave (
        output req_valid, req_op, req_a, req_b, alu_res, alu_done, rsp_ready,
        input  req_ready, alu_a, alu_b, alu_s, alu_rst, rsp_valid, rsp_data,
        input  rsp_err, busy
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: accepts one operation at a time, drives the ALU
// operands/opcode, sequences the multi-cycle mod unit (restart pulse, wait
// for done with timeout) and returns the result on a valid/ready channel.
module alu_issue_ctrl #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 16
) (
    input  logic              clk,
    input  logic              reset,
    alu_issue_ctrl_if.master  bus
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        EXEC = 3'd1,
        CLR  = 3'd2,
        WAIT = 3'd3,
        RESP = 3'd4
    } state_t;

    localparam logic [2:0]       OP_MOD   = 3'b111;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [31:0]      a_r, a_s;
    logic [31:0]      b_r, b_s;
    logic [2:0]       s_r, s_s;
    logic [31:0]      data_r, data_s;
    logic             err_r, err_s;

    // Next-state and next-register values; every register holds by default.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        a_s     = a_r;
        b_s     = b_r;
        s_s     = s_r;
        data_s  = data_r;
        err_s   = err_r;
        case (state_r)
            IDLE: begin
                if (bus.req_valid) begin
                    a_s = bus.req_a;
                    b_s = bus.req_b;
                    s_s = bus.req_op;
                    if (bus.req_op != OP_MOD) begin
                        state_s = EXEC;
                    end else if (bus.req_b == 32'd0) begin
                        // Mod by zero is answered at once; the mod unit is never restarted.
                        data_s  = 32'd0;
                        err_s   = 1'b1;
                        state_s = RESP;
                    end else begin
                        state_s = CLR;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            EXEC: begin
                data_s  = bus.alu_res;
                err_s   = 1'b0;
                state_s = RESP;
            end
            CLR: begin
                cnt_s   = {CNT_W{1'b0}};
                state_s = WAIT;
            end
            WAIT: begin
                // Exit at CNT_LAST happens before the counter could ever wrap.
                cnt_s = cnt_r + CNT_W'(1);
                if (bus.alu_done) begin
                    data_s  = bus.alu_res;
                    err_s   = 1'b0;
                    state_s = RESP;
                end else if (cnt_r == CNT_LAST) begin
                    data_s  = 32'd0;
                    err_s   = 1'b1;
                    state_s = RESP;
                end else begin
                    state_s = WAIT;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = RESP;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register, wait counter and operand/response registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            a_r     <= 32'd0;
            b_r     <= 32'd0;
            s_r     <= 3'd0;
            data_r  <= 32'd0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            a_r     <= a_s;
            b_r     <= b_s;
            s_r     <= s_s;
            data_r  <= data_s;
            err_r   <= err_s;
        end
    end

    // Handshake and status outputs are pure decodes of the state register.
    assign bus.req_ready = (state_r == IDLE);
    assign bus.rsp_valid = (state_r == RESP);
    assign bus.busy      = (state_r != IDLE);
    // The mod unit is also held in restart while this block is reset.
    assign bus.alu_rst   = reset | (state_r == CLR);
    assign bus.alu_a     = a_r;
    assign bus.alu_b     = b_r;
    assign bus.alu_s     = s_r;
    assign bus.rsp_data  = data_r;
    assign bus.rsp_err   = err_r;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed testbench for alu_issue_ctrl with a stub ALU and a response
// scoreboard.
module tb_alu_issue_ctrl;

    logic        clk     = 1'b0;
    logic        reset   = 1'b1;
    logic [31:0] mod_res = 32'd0;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc = 0;
    int          rst_pulses = 0;
    int          first_pulse = -1;
    logic [32:0] exp_q[$];

    alu_issue_ctrl_if bus();

    alu_issue_ctrl #(.TIMEOUT_CYCLES(8), .CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Stub ALU: adder for single-cycle ops, programmable result for mod.
    assign bus.alu_res = (bus.alu_s == 3'b111) ? mod_res : (bus.alu_a + bus.alu_b);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (bus.alu_rst) begin
            if (rst_pulses == 0) first_pulse = cyc;
            rst_pulses++;
        end
    endtask

    task automatic check_rsp(input string tag);
        logic [32:0] e;
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_data"}, bus.rsp_data, e[31:0]);
            chk({tag, "_err"}, {31'd0, bus.rsp_err}, {31'd0, e[32]});
        end
    endtask

    // One complete operation with rsp_ready high; done_at is the cycle
    // (counted from acceptance cycle 0) in which alu_done is raised, -1 = never.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_data,
                          input logic exp_err, input int done_at, input int exp_lat,
                          input int exp_pulses);
        exp_q.push_back({exp_err, exp_data});
        chk({tag, "_req_ready"}, {31'd0, bus.req_ready}, 32'd1);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.rsp_ready = 1'b1;
        cyc = 0;
        rst_pulses = 0;
        first_pulse = -1;
        step();
        bus.req_valid = 1'b0;
        bus.alu_done  = (cyc == done_at);
        while (!bus.rsp_valid && cyc < 40) begin
            step();
            bus.alu_done = (cyc == done_at);
        end
        bus.alu_done = 1'b0;
        chk({tag, "_rsp_valid"}, {31'd0, bus.rsp_valid}, 32'd1);
        chk({tag, "_latency"}, cyc, exp_lat);
        check_rsp(tag);
        chk({tag, "_rst_pulses"}, rst_pulses, exp_pulses);
        if (exp_pulses > 0) chk({tag, "_rst_cycle"}, first_pulse, 32'd1);
        step();
        chk({tag, "_rsp_drop"}, {31'd0, bus.rsp_valid}, 32'd0);
        chk({tag, "_ready_back"}, {31'd0, bus.req_ready}, 32'd1);
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_op    = 3'd0;
        bus.req_a     = 32'd0;
        bus.req_b     = 32'd0;
        bus.rsp_ready = 1'b1;
        bus.alu_done  = 1'b0;

        // Reset state
        #2;
        chk("rst_alu_rst", {31'd0, bus.alu_rst}, 32'd1);
        chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rst_alu_a", bus.alu_a, 32'd0);
        chk("rst_alu_s", {29'd0, bus.alu_s}, 32'd0);
        chk("rst_rsp_data", bus.rsp_data, 32'd0);
        chk("rst_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
        step();
        step();
        reset = 1'b0;
        #1;
        chk("rel_alu_rst", {31'd0, bus.alu_rst}, 32'd0);

        // Non-mod add; done raised during EXEC must be ignored
        run_op("add", 3'b000, 32'd5, 32'd7, 32'd12, 1'b0, 1, 2, 0);
        // Mod with done on the 5th WAIT cycle (cycle 6)
        mod_res = 32'd2;
        run_op("mod", 3'b111, 32'd100, 32'd7, 32'd2, 1'b0, 6, 7, 1);
        // Mod by zero: immediate error, no restart
        run_op("div0", 3'b111, 32'd9, 32'd0, 32'd0, 1'b1, 1, 1, 0);
        // Timeout after exactly 8 WAIT cycles
        run_op("tmo", 3'b111, 32'd20, 32'd3, 32'd0, 1'b1, -1, 10, 1);
        run_op("after_tmo", 3'b000, 32'd1, 32'd1, 32'd2, 1'b0, -1, 2, 0);

        // Backpressure: response held, next request waits for the handshake
        exp_q.push_back({1'b0, 32'd7});
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_op    = 3'b001;
        bus.req_a     = 32'd3;
        bus.req_b     = 32'd4;
        cyc = 0;
        step();
        bus.req_op = 3'b000;
        bus.req_a  = 32'd1;
        bus.req_b  = 32'd2;
        step();
        chk("bp_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
        check_rsp("bp_first");
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_hold_valid", {31'd0, bus.rsp_valid}, 32'd1);
            chk("bp_hold_data", bus.rsp_data, 32'd7);
            chk("bp_hold_err", {31'd0, bus.rsp_err}, 32'd0);
            chk("bp_hold_a", bus.alu_a, 32'd3);
            chk("bp_hold_b", bus.alu_b, 32'd4);
            chk("bp_hold_s", {29'd0, bus.alu_s}, 32'd1);
            chk("bp_req_ready", {31'd0, bus.req_ready}, 32'd0);
        end
        bus.rsp_ready = 1'b1;
        step();
        chk("bp_drop", {31'd0, bus.rsp_valid}, 32'd0);
        chk("bp_ready_back", {31'd0, bus.req_ready}, 32'd1);
        chk("bp_not_taken", bus.alu_a, 32'd3);
        exp_q.push_back({1'b0, 32'd3});
        step();
        bus.req_valid = 1'b0;
        chk("bp_taken_a", bus.alu_a, 32'd1);
        chk("bp_taken_s", {29'd0, bus.alu_s}, 32'd0);
        step();
        chk("bp_second_valid", {31'd0, bus.rsp_valid}, 32'd1);
        check_rsp("bp_second");
        step();

        // Reset two cycles into WAIT: op dropped, no response
        bus.req_valid = 1'b1;
        bus.req_op    = 3'b111;
        bus.req_a     = 32'd50;
        bus.req_b     = 32'd6;
        step();
        bus.req_valid = 1'b0;
        step();
        step();
        chk("rw_busy_before", {31'd0, bus.busy}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("rw_busy", {31'd0, bus.busy}, 32'd0);
        chk("rw_req_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("rw_alu_rst", {31'd0, bus.alu_rst}, 32'd1);
        chk("rw_alu_a", bus.alu_a, 32'd0);
        chk("rw_alu_s", {29'd0, bus.alu_s}, 32'd0);
        chk("rw_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        step();
        step();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rw_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
        end
        mod_res = 32'd1;
        run_op("rw_mod", 3'b111, 32'd10, 32'd3, 32'd1, 1'b0, 3, 4, 1);
        run_op("rw_tmo", 3'b111, 32'd11, 32'd5, 32'd0, 1'b1, -1, 10, 1);
        chk("sb_drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
